stack_eval_core: RTL

- Arithmetic core downstream of the token state machine. The state machine already sends built numbers and operator tokens to a calculator and reads back a ready flag and a 32-bit answer; this block is that calculator.
- It evaluates an infix expression one token at a time, using an operand stack and an operator stack (shunting-yard). '*' binds tighter than '+' and '-'; all operators are left-associative.
- The result goes back to the state machine for VGA and HEX display.

---
 rtl/stack_eval_core_if.sv | 22 ++
 rtl/stack_eval_core.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stack_eval_core_if.sv
// rtl/stack_eval_core_if.sv - token/answer bus between the token state machine and the calculator
interface stack_eval_core_if #(parameter int WIDTH = 32);
   logic             clear;
   logic             strobe;
   logic             is_op;
   logic [WIDTH-1:0] token;
   logic             ready;
   logic             answer_valid;
   logic [WIDTH-1:0] answer;
   logic             error;
   logic [2:0]       state_dbg;

   modport master (
      output clear, strobe, is_op, token,
      input  ready, answer_valid, answer, error, state_dbg
   );

   modport slave (
      input  clear, strobe, is_op, token,
      output ready, answer_valid, answer, error, state_dbg
   );
endinterface

// File: rtl/stack_eval_core.sv
// rtl/stack_eval_core.sv - shunting-yard infix calculator with operand and operator stacks
module stack_eval_core #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   stack_eval_core_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RED_OP = 3'd1,
      RED_EQ = 3'd2,
      DONE   = 3'd3,
      ERR    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2
   } op_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] opnd [DEPTH];
   op_t              ops  [DEPTH];
   logic [CW-1:0]    opnd_cnt, op_cnt;
   logic             expect_num;
   op_t              pend_op, tok_op, top_op;
   logic [WIDTH-1:0] answer_q;
   logic [WIDTH-1:0] opnd_a, opnd_b, red_val;
   logic [AW-1:0]    idx_a, idx_b, idx_o;
   logic             tok_op_valid, can_reduce, top_binds;
   logic             push_num, latch_op, push_op, reduce, load_ans;

   assign idx_b  = AW'(opnd_cnt - CW'(1));
   assign idx_a  = AW'(opnd_cnt - CW'(2));
   assign idx_o  = AW'(op_cnt - CW'(1));
   assign opnd_a = opnd[idx_a];
   assign opnd_b = opnd[idx_b];
   assign top_op = ops[idx_o];

   // Guarding the reduce on stack depth turns an impossible underflow into ERR.
   assign can_reduce = (opnd_cnt >= CW'(2)) && (op_cnt != '0);
   // Only '*' outranks; equal precedence reduces first for left associativity.
   assign top_binds  = (op_cnt != '0) && ((top_op == OP_MUL) || (pend_op != OP_MUL));

   always_comb begin
      red_val = opnd_a + opnd_b;
      case (top_op)
         OP_SUB:  red_val = opnd_a - opnd_b;
         OP_MUL:  red_val = opnd_a * opnd_b;
         default: red_val = opnd_a + opnd_b;
      endcase
   end

   always_comb begin
      tok_op_valid = 1'b1;
      tok_op       = OP_ADD;
      case (bus.token[3:0])
         4'hA:    tok_op = OP_ADD;
         4'hB:    tok_op = OP_SUB;
         4'hC:    tok_op = OP_MUL;
         default: tok_op_valid = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state;
      push_num = 1'b0;
      latch_op = 1'b0;
      push_op  = 1'b0;
      reduce   = 1'b0;
      load_ans = 1'b0;
      if (bus.clear) begin
         state_d = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.strobe) begin
                  if (!bus.is_op) begin
                     if (expect_num && (opnd_cnt != FULL)) push_num = 1'b1;
                     else                                  state_d  = ERR;
                  end else if (bus.token[3:0] == 4'hE) begin
                     state_d = expect_num ? ERR : RED_EQ;
                  end else if (!tok_op_valid || expect_num) begin
                     state_d = ERR;
                  end else begin
                     latch_op = 1'b1;
                     state_d  = RED_OP;
                  end
               end
            end
            RED_OP: begin
               if (top_binds) begin
                  if (can_reduce) reduce  = 1'b1;
                  else            state_d = ERR;
               end else if (op_cnt == FULL) begin
                  state_d = ERR;
               end else begin
                  push_op = 1'b1;
                  state_d = IDLE;
               end
            end
            RED_EQ: begin
               if (op_cnt != '0) begin
                  if (can_reduce) reduce  = 1'b1;
                  else            state_d = ERR;
               end else if (opnd_cnt == '0) begin
                  state_d = ERR;
               end else begin
                  load_ans = 1'b1;
                  state_d  = DONE;
               end
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = ERR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         opnd_cnt   <= '0;
         op_cnt     <= '0;
         expect_num <= 1'b1;
         pend_op    <= OP_ADD;
         answer_q   <= '0;
      end else begin
         state <= state_d;
         if (bus.clear) begin
            opnd_cnt   <= '0;
            op_cnt     <= '0;
            expect_num <= 1'b1;
            pend_op    <= OP_ADD;
            answer_q   <= '0;
         end else begin
            if (push_num) begin
               opnd_cnt   <= opnd_cnt + CW'(1);
               expect_num <= 1'b0;
            end
            if (latch_op) pend_op <= tok_op;
            if (push_op) begin
               op_cnt     <= op_cnt + CW'(1);
               expect_num <= 1'b1;
            end
            if (reduce) begin
               opnd_cnt <= opnd_cnt - CW'(1);
               op_cnt   <= op_cnt - CW'(1);
            end
            if (load_ans) answer_q <= opnd_b;
         end
      end
   end

   // Stack contents need no reset: the counters alone define what is live.
   always_ff @(posedge clk) begin
      if (push_num) opnd[AW'(opnd_cnt)] <= bus.token;
      if (reduce)   opnd[idx_a]         <= red_val;
      if (push_op)  ops[AW'(op_cnt)]    <= pend_op;
   end

   assign bus.ready        = (state == IDLE);
   assign bus.answer_valid = (state == DONE);
   assign bus.error        = (state == ERR);
   assign bus.answer       = answer_q;
   assign bus.state_dbg    = state;
endmodule
